// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster scan generator for the VGA colour driver. It divides clk_in down
//   to the pixel rate and walks a horizontal/vertical counter pair through
//   the visible area, porches and sync pulses. The defaults give
//   640x480@60 Hz from a 100 MHz board clock.
//
// Ports
//   clk_in        system clock
//   rst_in        synchronous reset, active high
//   current_row   horizontal counter h, 0..H_TOTAL-1
//   current_line  vertical counter v, 0..V_TOTAL-1
//   enable        high while (h, v) is inside the visible area
//   hsync         horizontal sync, active low
//   vsync         vertical sync, active low
//   pixel_tick    one-cycle strobe on the first clk_in cycle of each pixel
//   frame_start   one-cycle strobe on the first clk_in cycle of pixel (0,0)
//
// All outputs are registered. The visible-area and sync flags are decoded
// from the next-state counter values, so they line up with
// current_row/current_line in the same cycle.
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk_in,
  input  logic       rst_in,
  output logic [9:0] current_row,
  output logic [9:0] current_line,
  output logic       enable,
  output logic       hsync,
  output logic       vsync,
  output logic       pixel_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // With CLK_DIV=1 the divider is a single bit that never leaves 0.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Window bounds are 11 bits wide so that a window ending exactly at a
  // total of 1024 does not wrap to zero.
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
  localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div;
  logic             advance;
  logic [9:0]       h_next;
  logic [9:0]       v_next;
  logic [10:0]      h_ext;
  logic [10:0]      v_ext;

  always_comb begin
    advance = (div == DIV_LAST);
    h_next  = current_row;
    v_next  = current_line;
    if (advance) begin
      if (current_row == H_LAST) begin
        h_next = '0;
        v_next = (current_line == V_LAST) ? 10'd0 : current_line + 10'd1;
      end else begin
        h_next = current_row + 10'd1;
      end
    end
    h_ext = {1'b0, h_next};
    v_ext = {1'b0, v_next};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div          <= '0;
      current_row  <= '0;
      current_line <= '0;
      enable       <= 1'b1;
      hsync        <= 1'b1;
      vsync        <= 1'b1;
      pixel_tick   <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      div          <= advance ? '0 : div + 1'b1;
      current_row  <= h_next;
      current_line <= v_next;
      enable       <= (h_ext < H_VIS_END) && (v_ext < V_VIS_END);
      hsync        <= !((h_ext >= HS_START) && (h_ext < HS_END));
      vsync        <= !((v_ext >= VS_START) && (v_ext < VS_END));
      pixel_tick   <= advance;
      // An advance that lands on (0,0) can only come from the frame wrap.
      frame_start  <= advance && (h_next == 10'd0) && (v_next == 10'd0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Directed bench for vga_timing_gen. Three instances share one clock:
//   dut_a uses the default 640x480 timing, dut_b keeps the default
//   horizontal timing and CLK_DIV but a 6-line frame so whole frames fit in
//   a short run, and dut_c uses CLK_DIV=1 with a 14x7 raster. Expected
//   values come from hand-computed constants and a closed-form model of
//   the raster indexed by clk_in cycles since reset release.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  logic [9:0] row_a, line_a, row_b, line_b, row_c, line_c;
  logic en_a, hs_a, vs_a, pt_a, fs_a;
  logic en_b, hs_b, vs_b, pt_b, fs_b;
  logic en_c, hs_c, vs_c, pt_c, fs_c;

  int errors = 0;
  int checks = 0;

  vga_timing_gen dut_a (
    .clk_in(clk), .rst_in(rst_a), .current_row(row_a), .current_line(line_a),
    .enable(en_a), .hsync(hs_a), .vsync(vs_a), .pixel_tick(pt_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .CLK_DIV(4), .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_b (
    .clk_in(clk), .rst_in(rst_b), .current_row(row_b), .current_line(line_b),
    .enable(en_b), .hsync(hs_b), .vsync(vs_b), .pixel_tick(pt_b), .frame_start(fs_b)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut_c (
    .clk_in(clk), .rst_in(rst_c), .current_row(row_c), .current_line(line_c),
    .enable(en_c), .hsync(hs_c), .vsync(vs_c), .pixel_tick(pt_c), .frame_start(fs_c)
  );

  // Expected {row, line, enable, hsync, vsync, pixel_tick, frame_start}
  // n clk_in edges after reset release (n=0 is the reset state).
  function automatic logic [24:0] model(int n, int cd, int hv, int hf, int hw, int hb,
                                        int vv, int vf, int vw, int vb);
    int ht, vt, adv, h, v;
    logic en, hs, vs, pt, fs;
    ht  = hv + hf + hw + hb;
    vt  = vv + vf + vw + vb;
    adv = n / cd;
    h   = adv % ht;
    v   = (adv / ht) % vt;
    en  = (h < hv) && (v < vv);
    hs  = !((h >= hv + hf) && (h < hv + hf + hw));
    vs  = !((v >= vv + vf) && (v < vv + vf + vw));
    pt  = (n > 0) && (n % cd == 0);
    fs  = pt && (h == 0) && (v == 0);
    return {10'(h), 10'(v), en, hs, vs, pt, fs};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int hold_bad;
    hold_bad = 0;
    rst_a = 1'b1;
    repeat (3) tick();
    checks++;
    if ({row_a, line_a} !== 20'd0) begin
      errors++;
      $display("FAIL reset_counters: got row=%0d line=%0d, want 0 0", row_a, line_a);
    end
    checks++;
    if ({en_a, hs_a, vs_a, pt_a, fs_a} !== 5'b11100) begin
      errors++;
      $display("FAIL reset_flags: got en/hs/vs/pt/fs=%b, want 11100",
               {en_a, hs_a, vs_a, pt_a, fs_a});
    end
    rst_a = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (row_a !== 10'd0 || line_a !== 10'd0 || pt_a !== 1'b0 || fs_a !== 1'b0 ||
          en_a !== 1'b1 || hs_a !== 1'b1 || vs_a !== 1'b1)
        hold_bad++;
    end
    checks++;
    if (hold_bad !== 0) begin
      errors++;
      $display("FAIL reset_hold: %0d of 3 cycles left (0,0)/reset flags, want 0", hold_bad);
    end
    tick();
    checks++;
    if (row_a !== 10'd1 || line_a !== 10'd0) begin
      errors++;
      $display("FAIL first_advance: got row=%0d line=%0d, want 1 0", row_a, line_a);
    end
    checks++;
    if (pt_a !== 1'b1 || fs_a !== 1'b0) begin
      errors++;
      $display("FAIL first_tick: got pt=%b fs=%b, want 1 0", pt_a, fs_a);
    end
    tick();
    checks++;
    if (pt_a !== 1'b0 || row_a !== 10'd1) begin
      errors++;
      $display("FAIL tick_width: got pt=%b row=%0d, want 0 1", pt_a, row_a);
    end
  endtask

  task automatic test_hsweep();
    logic [24:0] e;
    int mdl_bad, fall_from, fall_to, hs_cnt, hs_first, hs_last;
    int wrap_n, wrap_line, wrap_prev_line, prev_row, prev_line;
    logic prev_en;
    mdl_bad = 0; fall_from = -1; fall_to = -1; hs_cnt = 0; hs_first = -1; hs_last = -1;
    wrap_n = -1; wrap_line = -1; wrap_prev_line = -1;
    rst_a = 1'b1;
    repeat (3) tick();
    rst_a = 1'b0;
    prev_row = 0; prev_line = 0; prev_en = 1'b1;
    for (int n = 1; n <= 3300; n++) begin
      tick();
      e = model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33);
      if ({row_a, line_a, en_a, hs_a, vs_a, pt_a, fs_a} !== e) mdl_bad++;
      if (prev_en && !en_a && fall_from < 0) begin
        fall_from = prev_row;
        fall_to   = int'(row_a);
      end
      if (!hs_a && line_a == 10'd0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(row_a);
        hs_last = int'(row_a);
      end
      if (prev_row == 799 && row_a == 10'd0 && wrap_n < 0) begin
        wrap_n         = n;
        wrap_prev_line = prev_line;
        wrap_line      = int'(line_a);
      end
      prev_row = int'(row_a); prev_line = int'(line_a); prev_en = en_a;
    end
    checks++;
    if (mdl_bad !== 0) begin
      errors++;
      $display("FAIL hsweep_model: %0d cycles differ from raster model, want 0", mdl_bad);
    end
    checks++;
    if (fall_from !== 639 || fall_to !== 640) begin
      errors++;
      $display("FAIL enable_fall: got row %0d->%0d, want 639->640", fall_from, fall_to);
    end
    checks++;
    if (hs_cnt !== 384) begin
      errors++;
      $display("FAIL hsync_width: got %0d cycles low, want 384", hs_cnt);
    end
    checks++;
    if (hs_first !== 656 || hs_last !== 751) begin
      errors++;
      $display("FAIL hsync_window: got rows %0d..%0d, want 656..751", hs_first, hs_last);
    end
    checks++;
    if (wrap_n !== 3200) begin
      errors++;
      $display("FAIL line_length: row wrapped after %0d cycles, want 3200", wrap_n);
    end
    checks++;
    if (wrap_prev_line !== 0 || wrap_line !== 1) begin
      errors++;
      $display("FAIL line_step: got line %0d->%0d at wrap, want 0->1", wrap_prev_line, wrap_line);
    end
  endtask

  task automatic test_vertical_frame();
    logic [24:0] e;
    int mdl_bad, en_bad, vs_cnt, vs_min, vs_max, lwrap_n, fs_cnt, fs_n0, fs_n1, fs_bad;
    int prev_line;
    logic prev_fs, seen_mid, mid_vs;
    mdl_bad = 0; en_bad = 0; vs_cnt = 0; vs_min = 99; vs_max = -1; lwrap_n = -1;
    fs_cnt = 0; fs_n0 = -1; fs_n1 = -1; fs_bad = 0; seen_mid = 1'b0; mid_vs = 1'b1;
    rst_b = 1'b1;
    repeat (3) tick();
    rst_b = 1'b0;
    prev_line = 0; prev_fs = 1'b0;
    for (int n = 1; n <= 38410; n++) begin
      tick();
      e = model(n, 4, 640, 16, 96, 48, 2, 1, 2, 1);
      if ({row_b, line_b, en_b, hs_b, vs_b, pt_b, fs_b} !== e) mdl_bad++;
      if (en_b && line_b >= 10'd2) en_bad++;
      if (!vs_b) begin
        if (n < 19200) vs_cnt++;
        if (int'(line_b) < vs_min) vs_min = int'(line_b);
        if (int'(line_b) > vs_max) vs_max = int'(line_b);
      end
      if (prev_line == 3 && line_b == 10'd4 && !seen_mid) begin
        seen_mid = 1'b1;
        mid_vs   = vs_b;
      end
      if (prev_line == 5 && line_b == 10'd0 && lwrap_n < 0) lwrap_n = n;
      if (fs_b) begin
        fs_cnt++;
        if (fs_n0 < 0) fs_n0 = n;
        else if (fs_n1 < 0) fs_n1 = n;
        if (pt_b !== 1'b1 || row_b !== 10'd0 || line_b !== 10'd0 || prev_fs) fs_bad++;
      end
      prev_line = int'(line_b); prev_fs = fs_b;
    end
    checks++;
    if (mdl_bad !== 0) begin
      errors++;
      $display("FAIL frame_model: %0d cycles differ from raster model, want 0", mdl_bad);
    end
    checks++;
    if (en_bad !== 0) begin
      errors++;
      $display("FAIL enable_vblank: enable high %0d cycles in lines >= 2, want 0", en_bad);
    end
    checks++;
    if (vs_cnt !== 6400) begin
      errors++;
      $display("FAIL vsync_width: got %0d cycles low in frame, want 6400", vs_cnt);
    end
    checks++;
    if (vs_min !== 3 || vs_max !== 4) begin
      errors++;
      $display("FAIL vsync_window: got lines %0d..%0d, want 3..4", vs_min, vs_max);
    end
    checks++;
    if ({seen_mid, mid_vs} !== 2'b10) begin
      errors++;
      $display("FAIL vsync_hwrap: got seen/vsync=%b%b at line 3->4, want 10", seen_mid, mid_vs);
    end
    checks++;
    if (lwrap_n !== 19200) begin
      errors++;
      $display("FAIL line_wrap: line 5->0 after %0d cycles, want 19200", lwrap_n);
    end
    checks++;
    if (fs_cnt !== 2 || fs_n0 !== 19200) begin
      errors++;
      $display("FAIL frame_start_count: got %0d pulses, first at %0d, want 2 at 19200", fs_cnt, fs_n0);
    end
    checks++;
    if (fs_n1 - fs_n0 !== 19200) begin
      errors++;
      $display("FAIL frame_period: got %0d cycles, want 19200", fs_n1 - fs_n0);
    end
    checks++;
    if (fs_bad !== 0) begin
      errors++;
      $display("FAIL frame_start_shape: %0d bad pulses (width/tick/origin), want 0", fs_bad);
    end
  endtask

  task automatic test_mid_reset();
    logic found;
    int hold_bad;
    found = 1'b0; hold_bad = 0;
    for (int i = 0; i < 20000 && !found; i++) begin
      tick();
      if (row_b == 10'd700 && line_b == 10'd4) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midreset_reach: row 700 line 4 not reached, got row=%0d line=%0d", row_b, line_b);
    end
    checks++;
    if ({hs_b, vs_b} !== 2'b00) begin
      errors++;
      $display("FAIL midreset_insync: got hsync/vsync=%b%b, want 00", hs_b, vs_b);
    end
    rst_b = 1'b1;
    tick();
    checks++;
    if ({row_b, line_b, en_b, hs_b, vs_b, pt_b, fs_b} !== {20'd0, 5'b11100}) begin
      errors++;
      $display("FAIL midreset_values: got row=%0d line=%0d flags=%b, want 0 0 11100",
               row_b, line_b, {en_b, hs_b, vs_b, pt_b, fs_b});
    end
    rst_b = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (row_b !== 10'd0 || line_b !== 10'd0 || pt_b !== 1'b0) hold_bad++;
    end
    tick();
    checks++;
    if (hold_bad !== 0 || row_b !== 10'd1 || pt_b !== 1'b1 || fs_b !== 1'b0) begin
      errors++;
      $display("FAIL midreset_restart: hold_bad=%0d row=%0d pt=%b fs=%b, want 0 1 1 0",
               hold_bad, row_b, pt_b, fs_b);
    end
  endtask

  task automatic test_clkdiv1();
    logic [24:0] e;
    int mdl_bad, pt_low, wrap_n, fs_n0, fs_n1, hs_cnt, vs_cnt, prev_row;
    mdl_bad = 0; pt_low = 0; wrap_n = -1; fs_n0 = -1; fs_n1 = -1; hs_cnt = 0; vs_cnt = 0;
    rst_c = 1'b1;
    repeat (3) tick();
    checks++;
    if (pt_c !== 1'b0 || row_c !== 10'd0) begin
      errors++;
      $display("FAIL div1_reset: got pt=%b row=%0d, want 0 0", pt_c, row_c);
    end
    rst_c = 1'b0;
    prev_row = 0;
    for (int n = 1; n <= 200; n++) begin
      tick();
      e = model(n, 1, 8, 2, 2, 2, 4, 1, 1, 1);
      if ({row_c, line_c, en_c, hs_c, vs_c, pt_c, fs_c} !== e) mdl_bad++;
      if (pt_c !== 1'b1) pt_low++;
      if (prev_row == 13 && row_c == 10'd0 && wrap_n < 0) wrap_n = n;
      if (fs_c) begin
        if (fs_n0 < 0) fs_n0 = n;
        else if (fs_n1 < 0) fs_n1 = n;
      end
      if (!hs_c && n < 14) hs_cnt++;
      if (!vs_c && n < 98) vs_cnt++;
      prev_row = int'(row_c);
    end
    checks++;
    if (mdl_bad !== 0) begin
      errors++;
      $display("FAIL div1_model: %0d cycles differ from raster model, want 0", mdl_bad);
    end
    checks++;
    if (pt_low !== 0) begin
      errors++;
      $display("FAIL div1_tick: pixel_tick low %0d cycles after first advance, want 0", pt_low);
    end
    checks++;
    if (wrap_n !== 14) begin
      errors++;
      $display("FAIL div1_line: got line length %0d, want 14", wrap_n);
    end
    checks++;
    if (fs_n0 !== 98 || fs_n1 !== 196) begin
      errors++;
      $display("FAIL div1_frame: got frame_start at %0d and %0d, want 98 and 196", fs_n0, fs_n1);
    end
    checks++;
    if (hs_cnt !== 2 || vs_cnt !== 14) begin
      errors++;
      $display("FAIL div1_sync: got hsync low %0d, vsync low %0d, want 2 and 14", hs_cnt, vs_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_hsweep();
    test_vertical_frame();
    test_mid_reset();
    test_clkdiv1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the raster scan that the VGA pixel/colour driver consumes: `current_row` (horizontal pixel, x), `current_line` (vertical line, y), `enable` (visible area), and active-low `hsync`/`vsync` for the connector.
- Divides the board clock down to the pixel rate and implements 640x480@60 Hz timing by default.
- Sits between the clock source and the colour driver; all outputs are registered and mutually aligned.

Parameters:
- CLK_DIV, 4, clk_in cycles per pixel (>=1; 100 MHz -> 25 MHz)
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk_in, input, 1, system clock
- rst_in, input, 1, synchronous active-high reset
- current_row, output, 10, horizontal counter h, 0..H_TOTAL-1
- current_line, output, 10, vertical counter v, 0..V_TOTAL-1
- enable, output, 1, high when h<H_VISIBLE and v<V_VISIBLE
- hsync, output, 1, horizontal sync, active low
- vsync, output, 1, vertical sync, active low
- pixel_tick, output, 1, one-cycle strobe, first clk_in cycle of each new pixel
- frame_start, output, 1, one-cycle strobe, first clk_in cycle of pixel (0,0)

Behaviour:
- Totals:
  - H_TOTAL = sum of the four H parameters (default 800).
  - V_TOTAL = sum of the four V parameters (default 525).
  - Both totals must be <=1024; counters are 10 bits.
- Divider:
  - div counts 0..CLK_DIV-1, then wraps.
  - Counters advance on the clk_in edge where div==CLK_DIV-1.
  - With CLK_DIV=1 the counters advance every cycle.
- Horizontal counter: h increments per advance; at H_TOTAL-1 it wraps to 0 and v increments.
- Vertical counter: when v==V_TOTAL-1 and h wraps, v wraps to 0 (frame end).
- Sync windows:
  - hsync=0 iff H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC (default 656..751).
  - vsync=0 iff V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC (default 490..491).
  - vsync depends on v only, never gated by h.
- Output alignment:
  - enable, hsync and vsync are decoded from next-state counter values and registered.
  - They therefore always match current_row/current_line in the same cycle. There is no pipeline skew and zero latency relative to the counters.
- Strobes:
  - pixel_tick is high in the cycle immediately following each counter advance; with CLK_DIV=1 it is constantly high after the first advance.
  - frame_start is high coincident with the pixel_tick that follows a wrap to (0,0).
- Reset:
  - rst_in is synchronous and active-high, and overrides everything, including mid-line and mid-sync.
  - Reset values: div=0, current_row=0, current_line=0, enable=1, hsync=1, vsync=1, pixel_tick=0, frame_start=0.
  - Reset entry does not assert frame_start.
  - After deassertion, (0,0) is held for exactly CLK_DIV cycles, then h=1.
- Periods (default parameters):
  - Line period = H_TOTAL*CLK_DIV = 3200 clk_in cycles.
  - Frame period = 800*525*4 = 1,680,000 clk_in cycles.
- No input other than rst_in alters the timing. Counters never exceed H_TOTAL-1 / V_TOTAL-1.

Test Plan:
- Reset release, defaults: rst_in high 3 cycles then low -> outputs (0,0), enable=1, hsync=vsync=1 for 4 cycles; current_row=1 on the 5th cycle with pixel_tick=1 for exactly 1 cycle.
- Horizontal sweep: run one line -> enable falls when current_row goes 639->640; hsync low for current_row 656..751 (96*4=384 clk_in cycles); current_row wraps 799->0 with current_line 0->1; line length 3200 cycles.
- Vertical timing: run a full frame -> enable=0 for all of lines 480..524; vsync low exactly for lines 490..491 (2 lines = 6400 cycles) and stays low through the h wrap between them; current_line wraps 524->0.
- Frame strobe: measure between consecutive frame_start pulses -> 1,680,000 cycles; each pulse is 1 cycle wide, coincident with pixel_tick, with current_row=0 and current_line=0; no pulse at reset release.
- Mid-operation reset: assert rst_in at current_row=700, current_line=491 (inside both syncs) -> next cycle outputs equal reset values (hsync=vsync=1, (0,0)), and timing restarts as in the reset-release test.
- CLK_DIV=1, small timing (H 8/2/2/2, V 4/1/1/1): counters advance every cycle; pixel_tick is constantly high after the first advance; line=14 cycles, frame=98 cycles; hsync low at h=10..11, vsync low at v=5.
